keccak_absorb_buffer: RTL and testbench



---
 rtl/keccak_pkg.sv | 18 +
 rtl/keccak_pad_lane.sv | 34 +++
 rtl/keccak_absorb_buffer.sv | 105 ++++++++++
 tb/tb_keccak_absorb_buffer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak absorb front end.
// Lane/rate geometry, the final pad bit and the buffer FSM encoding.
package keccak_pkg;

  localparam int LANE_W     = 64;
  localparam int RATE_LANES = 9;
  localparam int RATE_W     = LANE_W * RATE_LANES;
  localparam int STATE_W    = 1600;
  localparam int LANE_BYTES = LANE_W / 8;

  localparam logic [7:0] PAD_FINAL = 8'h80;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/keccak_pad_lane.sv
// Masks the final message word to its valid bytes, inserts the pad byte after
// them and, for the top lane of the rate, ORs in the closing 0x80.
module keccak_pad_lane
  import keccak_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h01
) (
  input  logic [LANE_W-1:0] word_i,
  input  logic [2:0]        bytes_i,
  input  logic              is_last_i,
  input  logic              is_top_lane_i,
  output logic [LANE_W-1:0] lane_o
);

  always_comb begin
    lane_o = word_i;
    if (is_last_i) begin
      for (int b = 0; b < LANE_BYTES; b++) begin
        if (b < int'(bytes_i)) begin
          lane_o[8*b +: 8] = word_i[8*b +: 8];
        end else if (b == int'(bytes_i)) begin
          lane_o[8*b +: 8] = PAD_BYTE;
        end else begin
          lane_o[8*b +: 8] = 8'h00;
        end
      end
      // Pad byte and final bit may share byte 7 when in_bytes==7 (0x81).
      if (is_top_lane_i) begin
        lane_o[LANE_W-1 -: 8] = lane_o[LANE_W-1 -: 8] | PAD_FINAL;
      end
    end
  end

endmodule

// File: rtl/keccak_absorb_buffer.sv
// Packs 64-bit message words into 576-bit rate blocks, pads the final block
// and hands each block downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The source holds data/valid stable until that edge; ready never depends
// combinationally on valid. in_ready and blk_valid are decoded from state only
// and are mutually exclusive, so there is one bubble cycle after each handoff.
module keccak_absorb_buffer #(
  parameter int         LANE_W     = keccak_pkg::LANE_W,
  parameter int         RATE_LANES = keccak_pkg::RATE_LANES,
  parameter logic [7:0] PAD_BYTE   = 8'h01
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANE_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [2:0]                   in_bytes,
  output logic [LANE_W*RATE_LANES-1:0] blk_data,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic                         blk_last,
  output keccak_pkg::state_e           dbg_state
);

  import keccak_pkg::*;

  localparam int BLK_W = LANE_W * RATE_LANES;
  localparam int CNT_W = $clog2(RATE_LANES);
  localparam logic [CNT_W-1:0] TOP_LANE = CNT_W'(RATE_LANES - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BLK_W-1:0]   blk_data_q;
  logic               blk_last_q;
  logic [LANE_W-1:0]  lane_d;
  logic               accept;
  logic               handoff;
  logic               is_top_lane;

  assign in_ready    = (state_q == FILL);
  assign blk_valid   = (state_q == HOLD);
  assign blk_data    = blk_data_q;
  assign blk_last    = blk_last_q;
  assign dbg_state   = state_q;

  assign accept      = in_valid && in_ready;
  assign handoff     = blk_valid && blk_ready;
  assign is_top_lane = (cnt_q == TOP_LANE);

  keccak_pad_lane #(
    .PAD_BYTE (PAD_BYTE)
  ) u_pad_lane (
    .word_i        (in_data),
    .bytes_i       (in_bytes),
    .is_last_i     (in_last),
    .is_top_lane_i (is_top_lane),
    .lane_o        (lane_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      blk_data_q <= '0;
      blk_last_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            blk_data_q[int'(cnt_q)*LANE_W +: LANE_W] <= lane_d;
            if (in_last) begin
              // Lanes above cnt are still zero from the last handoff, so the
              // closing bit is simply set when the pad lane is not the top one.
              if (!is_top_lane) begin
                blk_data_q[BLK_W-1] <= 1'b1;
              end
              blk_last_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= HOLD;
            end else if (is_top_lane) begin
              blk_last_q <= 1'b0;
              cnt_q      <= '0;
              state_q    <= HOLD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (handoff) begin
            blk_data_q <= '0;
            blk_last_q <= 1'b0;
            state_q    <= FILL;
          end
        end
        default: begin
          state_q <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_absorb_buffer.sv
// Directed bench for keccak_absorb_buffer: one task per scenario, expected
// blocks hand-built from the padding rules.
module tb_keccak_absorb_buffer;

  logic               clk;
  logic               rst_n;
  logic [63:0]        in_data;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic [2:0]         in_bytes;
  logic [575:0]       blk_data;
  logic               blk_valid;
  logic               blk_ready;
  logic               blk_last;
  keccak_pkg::state_e dbg_state;

  int n_checks;
  int n_fail;

  keccak_absorb_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_bytes  (in_bytes),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present one word and hold it until accepted
  task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] nb);
    int n;
    n = 0;
    @(negedge clk);
    in_data  = d;
    in_last  = last;
    in_bytes = nb;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_word_ready: in_ready=%b after %0d cycles, required 1", in_ready, n);
      n_fail++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_bytes = 3'd0;
  endtask

  // wait for a block, compare it, then consume it
  task automatic expect_block(input logic [575:0] exp, input logic exp_last, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (blk_valid !== 1'b1) begin
      $display("FAIL %s_valid: blk_valid=%b, required 1", name, blk_valid);
      n_fail++;
    end
    n_checks++;
    if (blk_data !== exp) begin
      $display("FAIL %s_data: got %h required %h", name, blk_data, exp);
      n_fail++;
    end
    n_checks++;
    if (blk_last !== exp_last) begin
      $display("FAIL %s_last: got %b required %b", name, blk_last, exp_last);
      n_fail++;
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (blk_valid !== 1'b0 || blk_data !== '0 || blk_last !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_after_handoff: valid=%b last=%b ready=%b data_zero=%b, required 0 0 1 1",
               name, blk_valid, blk_last, in_ready, (blk_data == '0));
      n_fail++;
    end
  endtask

  function automatic logic [575:0] empty_block();
    logic [575:0] e;
    e        = '0;
    e[7:0]   = 8'h01;
    e[575]   = 1'b1;
    return e;
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_bytes  = 3'd0;
    blk_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (blk_valid !== 1'b0 || blk_last !== 1'b0 || blk_data !== '0 || dbg_state !== keccak_pkg::FILL) begin
      $display("FAIL reset_values: valid=%b last=%b state=%0d data_zero=%b, required 0 0 0 1",
               blk_valid, blk_last, dbg_state, (blk_data == '0));
      n_fail++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
      n_fail++;
    end
  endtask

  task automatic test_ready_in_fill();
    @(negedge clk);
    blk_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
        $display("FAIL fill_blk_ready: blk_valid=%b in_ready=%b, required 0 1", blk_valid, in_ready);
        n_fail++;
      end
    end
    blk_ready = 1'b0;
  endtask

  task automatic test_empty();
    send_word(64'h1234_5678_9ABC_DEF0, 1'b1, 3'd0);
    // registered at the accepting edge, visible just after it
    n_checks++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b1) begin
      $display("FAIL empty_latency: valid=%b last=%b, required 1 1", blk_valid, blk_last);
      n_fail++;
    end
    expect_block(empty_block(), 1'b1, "empty");
  endtask

  task automatic test_nine_words();
    logic [575:0] e;
    e = '0;
    for (int k = 0; k < 9; k++) begin
      send_word(64'(k), 1'b0, 3'd0);
      e[64*k +: 64] = 64'(k);
    end
    expect_block(e, 1'b0, "nine_words");
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd0);
    expect_block(empty_block(), 1'b1, "nine_words_tail");
  endtask

  task automatic test_full_tail();
    logic [575:0] e;
    e = '0;
    for (int k = 0; k < 8; k++) begin
      send_word({8{8'(k + 1)}}, 1'b0, 3'd0);
      e[64*k +: 64] = {8{8'(k + 1)}};
    end
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd7);
    e[64*8 +: 64] = 64'h81FF_FFFF_FFFF_FFFF;
    expect_block(e, 1'b1, "full_tail");
  endtask

  task automatic test_partial();
    logic [575:0] e;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      send_word({8{8'(8'hA0 + k)}}, 1'b0, 3'd0);
      e[64*k +: 64] = {8{8'(8'hA0 + k)}};
    end
    send_word(64'hDEAD_BEEF_CAFE_BABE, 1'b1, 3'd3);
    // bytes 0..2 kept, byte 3 = pad byte, rest cleared
    e[64*3 +: 64] = 64'h0000_0000_01FE_BABE;
    e[64*8 +: 64] = 64'h8000_0000_0000_0000;
    expect_block(e, 1'b1, "partial");
  endtask

  task automatic test_hold();
    logic [575:0] e;
    logic [575:0] e2;
    e = '0;
    for (int k = 0; k < 9; k++) begin
      send_word(64'h100 + 64'(k), 1'b0, 3'd0);
      e[64*k +: 64] = 64'h100 + 64'(k);
    end
    @(negedge clk);
    in_data   = 64'h0000_0000_0000_ABCD;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    blk_ready = 1'b0;
    repeat (20) begin
      @(negedge clk);
      n_checks++;
      if (blk_data !== e || in_ready !== 1'b0 || blk_valid !== 1'b1 || blk_last !== 1'b0) begin
        $display("FAIL hold_stable: valid=%b ready=%b last=%b data=%h required data %h",
                 blk_valid, in_ready, blk_last, blk_data, e);
        n_fail++;
      end
    end
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    n_checks++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL hold_bubble: blk_valid=%b in_ready=%b, required 0 1", blk_valid, in_ready);
      n_fail++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send_word(64'h0, 1'b1, 3'd0);
    e2 = '0;
    e2[63:0]    = 64'h0000_0000_0000_ABCD;
    e2[71:64]   = 8'h01;
    e2[575]     = 1'b1;
    expect_block(e2, 1'b1, "hold_next");
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 5; k++) begin
      send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (blk_valid !== 1'b0 || blk_data !== '0 || dbg_state !== keccak_pkg::FILL) begin
      $display("FAIL mid_reset_clear: valid=%b state=%0d data_zero=%b, required 0 0 1",
               blk_valid, dbg_state, (blk_data == '0));
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_word(64'h0, 1'b1, 3'd0);
    expect_block(empty_block(), 1'b1, "mid_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ready_in_fill();
    test_empty();
    test_nine_words();
    test_full_tail();
    test_partial();
    test_hold();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
